cc_maxseq_controller: RTL and testbench
=======================================

# cc_maxseq_controller

Sequencing controller that finds the maximum of a burst of NUMBER_ELEMENTS unsigned values by time-sharing one external strict-greater-than comparator. On a start pulse it accepts elements one at a time over a valid/ready handshake and presents (candidate, running max) to the comparator. It samples the comparator result and updates the running max and its index, then reports max, index and a done pulse. It sits between the neuron datapath's value stream and the shared comparator instance.

## Interface
- NUMBER_DATAWIDTH, 8, element and comparator operand width (unsigned)
- NUMBER_ELEMENTS, 4, elements per burst (≥1)
- NUMBER_INDEXWIDTH, $clog2(NUMBER_ELEMENTS) min 1, width of index/counter
- CC_MAXSEQ_CLOCK_50  in  1  single clock, all logic on rising edge
- CC_MAXSEQ_RESET_InLow  in  1  synchronous, active-low reset
- CC_MAXSEQ_start_In  in  1  start request, sampled only in IDLE
- CC_MAXSEQ_data_InBUS  in  NUMBER_DATAWIDTH  element value
- CC_MAXSEQ_dataValid_In  in  1  element valid
- CC_MAXSEQ_dataReady_Out  out  1  controller can accept element
- CC_MAXSEQ_cmpA_OutBUS  out  NUMBER_DATAWIDTH  comparator c0 operand (candidate register)
- CC_MAXSEQ_cmpB_OutBUS  out  NUMBER_DATAWIDTH  comparator c1 operand (running-max register)
- CC_MAXSEQ_cmpResult_In  in  1  comparator result, 1 when c0 > c1
- CC_MAXSEQ_max_OutBUS  out  NUMBER_DATAWIDTH  maximum of last completed burst
- CC_MAXSEQ_maxIndex_OutBUS  out  NUMBER_INDEXWIDTH  arrival index (0-based) of that maximum
- CC_MAXSEQ_busy_Out  out  1  high in every state except IDLE
- CC_MAXSEQ_done_Out  out  1  one-cycle pulse, results valid

## Operation
- States: IDLE, FIRST, ACCEPT, COMPARE, DONE.
- IDLE: ready=0. start=1 → FIRST. Other inputs are ignored.
- FIRST: ready=1. Handshake (valid&ready) stores the element into the max register, sets index=0 and count=1. Next state is DONE if NUMBER_ELEMENTS=1, else ACCEPT. No handshake means stay.
- ACCEPT: ready=1. Handshake stores the element into the candidate register → COMPARE. No handshake means stay; stalls are unbounded.
- COMPARE: ready=0. The comparator sees registered operands, so the path is purely combinational through the external comparator. The controller samples cmpResult_In at the end of the cycle.
  - result=1 → max←candidate, index←count.
  - count←count+1.
  - If count+1 = NUMBER_ELEMENTS → DONE, else ACCEPT.
- DONE: done_Out=1 for exactly one cycle, then → IDLE.
- max_OutBUS and maxIndex_OutBUS are the max/index registers. They are only guaranteed meaningful during and after DONE, and they hold until the next burst's FIRST handshake.
- Ties: the comparator is strict, so an equal value never replaces the max. The earliest index wins.
- start_In outside IDLE is ignored; there is no queuing and no restart.
- Reset (RESET_InLow=0 at a clock edge), in any state including mid-burst:
  - state → IDLE
  - all registers zero: max, index, candidate, count, cmpA, cmpB
  - ready=0, busy=0, done=0
  - any partially accepted burst is discarded.
- Comparison is unsigned, NUMBER_DATAWIDTH bits. The counter never wraps, because it is compared against NUMBER_ELEMENTS.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from data/valid to any output.
- With valid held high and start in cycle 0:
  - cycle 1 is FIRST
  - cycles 2..2N−1 alternate ACCEPT/COMPARE
  - done_Out is high in cycle 2N (N=4 → cycle 8; N=1 → cycle 2).
- Throughput: one element per 2 cycles after the first. The comparator is busy only in COMPARE cycles.
- Each cycle of valid=0 during FIRST/ACCEPT adds exactly one cycle of latency.
- done_Out and busy_Out are both high in the DONE cycle. busy_Out falls on the following edge.

## Structure
- Package cc_maxseq_pkg holds:
  - state encoding localparams (IDLE=0, FIRST=1, ACCEPT=2, COMPARE=3, DONE=4; 3-bit)
  - default NUMBER_DATAWIDTH
- One natural sub-module: cc_maxseq_counter, the element counter with clear, increment and last-element flag (count+1 = NUMBER_ELEMENTS).
- The comparator stays outside the block so other requesters can share it through the cmp ports.
- Bench instantiates the team comparator between cmpA/cmpB and cmpResult_In.

## Test plan
- N=4, valid always high, values 3,9,2,7 → done in cycle 8, max=9, index=1.
- Ties: 5,5,1,5 → max=5, index=0. Values 0,0,0,255 → max=255, index=3.
- valid low for 3 cycles before element 2, with data 10,20,30,40 → done delayed by exactly 3 cycles (cycle 11), max=40, index=3.
- start pulsed again in cycles 3 and 5 → ignored. Exactly one done pulse, in cycle 8, and the result is unchanged.
- Reset asserted in the first COMPARE cycle → next edge: IDLE, all outputs 0. Then a new burst 1,2,3,4 → max=4, index=3, done 8 cycles after its start.
- NUMBER_ELEMENTS=1, value 42 → done in cycle 2, max=42, index=0, and cmpResult_In is never sampled.

Source files
------------

// File: rtl/cc_maxseq_pkg.sv
// Shared state encoding and defaults for the max-sequencing controller.
package cc_maxseq_pkg;

  localparam int DEFAULT_DATAWIDTH = 8;

  localparam logic [2:0] ENC_IDLE    = 3'd0;
  localparam logic [2:0] ENC_FIRST   = 3'd1;
  localparam logic [2:0] ENC_ACCEPT  = 3'd2;
  localparam logic [2:0] ENC_COMPARE = 3'd3;
  localparam logic [2:0] ENC_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ENC_IDLE,
    FIRST   = ENC_FIRST,
    ACCEPT  = ENC_ACCEPT,
    COMPARE = ENC_COMPARE,
    DONE    = ENC_DONE
  } stateType;

  // A single-element burst still needs a one-bit index.
  function automatic int indexWidth(input int elements);
    return (elements > 1) ? $clog2(elements) : 1;
  endfunction

endpackage

// File: rtl/cc_maxseq_counter.sv
// Element counter for one burst; flags when the element being retired is the last one.
module cc_maxseq_counter #(
  parameter int NUMBER_ELEMENTS = 4,
  parameter int COUNT_WIDTH     = 3
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   clear,
  input  logic                   increment,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   lastElement
);

  // One spare bit over the index width so count can reach NUMBER_ELEMENTS without wrapping.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (increment) begin
      count <= count + COUNT_WIDTH'(1);
    end
  end

  assign lastElement = ((count + COUNT_WIDTH'(1)) == COUNT_WIDTH'(NUMBER_ELEMENTS));

endmodule

// File: rtl/cc_maxseq_controller.sv
// Finds the maximum of a burst by time-sharing an external strict-greater-than comparator.
module cc_maxseq_controller
  import cc_maxseq_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH  = DEFAULT_DATAWIDTH,
  parameter int NUMBER_ELEMENTS   = 4,
  parameter int NUMBER_INDEXWIDTH = indexWidth(NUMBER_ELEMENTS)
) (
  input  logic                         CC_MAXSEQ_CLOCK_50,
  input  logic                         CC_MAXSEQ_RESET_InLow,
  input  logic                         CC_MAXSEQ_start_In,
  input  logic [NUMBER_DATAWIDTH-1:0]  CC_MAXSEQ_data_InBUS,
  input  logic                         CC_MAXSEQ_dataValid_In,
  output logic                         CC_MAXSEQ_dataReady_Out,
  output logic [NUMBER_DATAWIDTH-1:0]  CC_MAXSEQ_cmpA_OutBUS,
  output logic [NUMBER_DATAWIDTH-1:0]  CC_MAXSEQ_cmpB_OutBUS,
  input  logic                         CC_MAXSEQ_cmpResult_In,
  output logic [NUMBER_DATAWIDTH-1:0]  CC_MAXSEQ_max_OutBUS,
  output logic [NUMBER_INDEXWIDTH-1:0] CC_MAXSEQ_maxIndex_OutBUS,
  output logic                         CC_MAXSEQ_busy_Out,
  output logic                         CC_MAXSEQ_done_Out
);

  localparam int COUNT_WIDTH = NUMBER_INDEXWIDTH + 1;

  stateType                   state;
  stateType                   nextState;
  logic                       handshake;
  logic                       counterClear;
  logic                       counterInc;
  logic [COUNT_WIDTH-1:0]     count;
  logic                       lastElement;
  logic [NUMBER_DATAWIDTH-1:0]  maxReg;
  logic [NUMBER_DATAWIDTH-1:0]  candReg;
  logic [NUMBER_INDEXWIDTH-1:0] indexReg;

  assign handshake = CC_MAXSEQ_dataValid_In & CC_MAXSEQ_dataReady_Out;

  cc_maxseq_counter #(
    .NUMBER_ELEMENTS (NUMBER_ELEMENTS),
    .COUNT_WIDTH     (COUNT_WIDTH)
  ) elementCounter (
    .clk         (CC_MAXSEQ_CLOCK_50),
    .resetN      (CC_MAXSEQ_RESET_InLow),
    .clear       (counterClear),
    .increment   (counterInc),
    .count       (count),
    .lastElement (lastElement)
  );

  always_ff @(posedge CC_MAXSEQ_CLOCK_50) begin
    if (!CC_MAXSEQ_RESET_InLow) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState    = state;
    counterClear = 1'b0;
    counterInc   = 1'b0;
    case (state)
      IDLE: begin
        if (CC_MAXSEQ_start_In) begin
          nextState    = FIRST;
          counterClear = 1'b1;
        end
      end
      FIRST: begin
        if (handshake) begin
          counterInc = 1'b1;
          nextState  = lastElement ? DONE : ACCEPT;
        end
      end
      ACCEPT: begin
        if (handshake) begin
          nextState = COMPARE;
        end
      end
      COMPARE: begin
        counterInc = 1'b1;
        nextState  = lastElement ? DONE : ACCEPT;
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Comparator result is only trusted in COMPARE, where both operands are already registered.
  always_ff @(posedge CC_MAXSEQ_CLOCK_50) begin
    if (!CC_MAXSEQ_RESET_InLow) begin
      maxReg   <= '0;
      candReg  <= '0;
      indexReg <= '0;
    end else begin
      if ((state == FIRST) && handshake) begin
        maxReg   <= CC_MAXSEQ_data_InBUS;
        indexReg <= '0;
      end
      if ((state == ACCEPT) && handshake) begin
        candReg <= CC_MAXSEQ_data_InBUS;
      end
      if ((state == COMPARE) && CC_MAXSEQ_cmpResult_In) begin
        maxReg   <= candReg;
        indexReg <= count[NUMBER_INDEXWIDTH-1:0];
      end
    end
  end

  assign CC_MAXSEQ_dataReady_Out   = (state == FIRST) || (state == ACCEPT);
  assign CC_MAXSEQ_busy_Out        = (state != IDLE);
  assign CC_MAXSEQ_done_Out        = (state == DONE);
  assign CC_MAXSEQ_cmpA_OutBUS     = candReg;
  assign CC_MAXSEQ_cmpB_OutBUS     = maxReg;
  assign CC_MAXSEQ_max_OutBUS      = maxReg;
  assign CC_MAXSEQ_maxIndex_OutBUS = indexReg;

endmodule

// File: tb/tb_cc_maxseq_controller.sv
// Scoreboard bench for cc_maxseq_controller: a 4-element instance and a 1-element instance.
module tb_cc_maxseq_controller;

  typedef struct {
    logic [7:0] maxVal;
    int         idx;
    int         doneCycle;
  } expType;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetN;
  logic       start4, valid4, ready4, cmpRes4, busy4, done4;
  logic [7:0] data4, cmpA4, cmpB4, max4;
  logic [1:0] idx4;
  logic       start1, valid1, ready1, cmpRes1, busy1, done1;
  logic [7:0] data1, cmpA1, cmpB1, max1;
  logic [0:0] idx1;

  int     compared   = 0;
  int     mismatched = 0;
  int     cycle      = 0;
  expType q4[$];
  expType q1[$];
  expType e4, e1;
  logic   prevDone4 = 1'b0;
  logic   prevDone1 = 1'b0;

  // Team comparator sits between the operand ports and the result input.
  assign cmpRes4 = (cmpA4 > cmpB4);
  // Held high so any wrongful sample in the single-element instance corrupts its result.
  assign cmpRes1 = 1'b1;

  cc_maxseq_controller #(.NUMBER_DATAWIDTH(8), .NUMBER_ELEMENTS(4), .NUMBER_INDEXWIDTH(2)) dut4 (
    .CC_MAXSEQ_CLOCK_50        (clk),
    .CC_MAXSEQ_RESET_InLow     (resetN),
    .CC_MAXSEQ_start_In        (start4),
    .CC_MAXSEQ_data_InBUS      (data4),
    .CC_MAXSEQ_dataValid_In    (valid4),
    .CC_MAXSEQ_dataReady_Out   (ready4),
    .CC_MAXSEQ_cmpA_OutBUS     (cmpA4),
    .CC_MAXSEQ_cmpB_OutBUS     (cmpB4),
    .CC_MAXSEQ_cmpResult_In    (cmpRes4),
    .CC_MAXSEQ_max_OutBUS      (max4),
    .CC_MAXSEQ_maxIndex_OutBUS (idx4),
    .CC_MAXSEQ_busy_Out        (busy4),
    .CC_MAXSEQ_done_Out        (done4)
  );

  cc_maxseq_controller #(.NUMBER_DATAWIDTH(8), .NUMBER_ELEMENTS(1), .NUMBER_INDEXWIDTH(1)) dut1 (
    .CC_MAXSEQ_CLOCK_50        (clk),
    .CC_MAXSEQ_RESET_InLow     (resetN),
    .CC_MAXSEQ_start_In        (start1),
    .CC_MAXSEQ_data_InBUS      (data1),
    .CC_MAXSEQ_dataValid_In    (valid1),
    .CC_MAXSEQ_dataReady_Out   (ready1),
    .CC_MAXSEQ_cmpA_OutBUS     (cmpA1),
    .CC_MAXSEQ_cmpB_OutBUS     (cmpB1),
    .CC_MAXSEQ_cmpResult_In    (cmpRes1),
    .CC_MAXSEQ_max_OutBUS      (max1),
    .CC_MAXSEQ_maxIndex_OutBUS (idx1),
    .CC_MAXSEQ_busy_Out        (busy1),
    .CC_MAXSEQ_done_Out        (done1)
  );

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // Pops one expectation per done pulse; busy must drop on the edge after done.
  always @(negedge clk) begin
    if (prevDone4) checkOutput("busyAfterDone4", {31'd0, busy4}, 32'd0);
    prevDone4 <= done4;
    if (done4 === 1'b1) begin
      checkOutput("busyInDone4", {31'd0, busy4}, 32'd1);
      if (q4.size() == 0) begin
        checkOutput("spuriousDone4", {31'd0, done4}, 32'd0);
      end else begin
        e4 = q4.pop_front();
        checkOutput("max4", {24'd0, max4}, {24'd0, e4.maxVal});
        checkOutput("index4", {30'd0, idx4}, e4.idx);
        checkOutput("doneCycle4", cycle, e4.doneCycle);
      end
    end
  end

  always @(negedge clk) begin
    if (prevDone1) checkOutput("busyAfterDone1", {31'd0, busy1}, 32'd0);
    prevDone1 <= done1;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checkOutput("spuriousDone1", {31'd0, done1}, 32'd0);
      end else begin
        e1 = q1.pop_front();
        checkOutput("max1", {24'd0, max1}, {24'd0, e1.maxVal});
        checkOutput("index1", {31'd0, idx1}, e1.idx);
        checkOutput("doneCycle1", cycle, e1.doneCycle);
        checkOutput("candidate1", {24'd0, cmpA1}, 32'd0);
      end
    end
  end

  // Waits gap ready-high cycles with valid low, then offers v until it is taken.
  task automatic sendElement4(input logic [7:0] v, input int gap);
    int guard = 0;
    int left  = gap;
    if (left > 0) valid4 = 1'b0;
    while (left > 0 && guard < 100) begin
      if (ready4) left--;
      @(negedge clk);
      guard++;
    end
    valid4 = 1'b1;
    data4  = v;
    while (!ready4 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("readyTimeout4", {31'd0, ready4}, 32'd1);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                               input logic [7:0] v3, input int gapLen, input bit extraStarts);
    logic [7:0] vals [4];
    expType     e;
    int         c0;
    vals = '{v0, v1, v2, v3};
    e.maxVal = vals[0];
    e.idx    = 0;
    for (int k = 1; k < 4; k++) begin
      if (vals[k] > e.maxVal) begin
        e.maxVal = vals[k];
        e.idx    = k;
      end
    end
    c0 = cycle;
    e.doneCycle = c0 + 8 + gapLen;
    q4.push_back(e);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    fork
      begin
        if (extraStarts) begin
          repeat (2) @(negedge clk);
          start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          @(negedge clk);
          start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
        end
      end
      begin
        for (int k = 0; k < 4; k++) sendElement4(vals[k], (k == 1) ? gapLen : 0);
        valid4 = 1'b0;
      end
    join
  endtask

  task automatic applySingle(input logic [7:0] v);
    expType e;
    int     guard = 0;
    e.maxVal    = v;
    e.idx       = 0;
    e.doneCycle = cycle + 2;
    q1.push_back(e);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    valid1 = 1'b1;
    data1  = v;
    while (!ready1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("readyTimeout1", {31'd0, ready1}, 32'd1);
    @(negedge clk);
    valid1 = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 60 && (q4.size() > 0 || q1.size() > 0); w++) @(negedge clk);
    if (q4.size() > 0 || q1.size() > 0) checkOutput("drainTimeout", q4.size() + q1.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkResetState4(input string pfx);
    checkOutput({pfx, "Ready"}, {31'd0, ready4}, 32'd0);
    checkOutput({pfx, "Busy"},  {31'd0, busy4},  32'd0);
    checkOutput({pfx, "Done"},  {31'd0, done4},  32'd0);
    checkOutput({pfx, "Max"},   {24'd0, max4},   32'd0);
    checkOutput({pfx, "Index"}, {30'd0, idx4},   32'd0);
    checkOutput({pfx, "CmpA"},  {24'd0, cmpA4},  32'd0);
    checkOutput({pfx, "CmpB"},  {24'd0, cmpB4},  32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation did not finish, cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN = 1'b0;
    start4 = 1'b0; valid4 = 1'b0; data4 = '0;
    start1 = 1'b0; valid1 = 1'b0; data1 = '0;
    repeat (3) @(negedge clk);
    checkResetState4("reset4");
    checkOutput("reset1Busy", {31'd0, busy1}, 32'd0);
    checkOutput("reset1Max",  {24'd0, max1},  32'd0);
    resetN = 1'b1;
    @(negedge clk);

    applyStimulus(8'd3, 8'd9, 8'd2, 8'd7, 0, 1'b0);      drain();
    applyStimulus(8'd5, 8'd5, 8'd1, 8'd5, 0, 1'b0);      drain();
    applyStimulus(8'd0, 8'd0, 8'd0, 8'd255, 0, 1'b0);    drain();
    applyStimulus(8'd10, 8'd20, 8'd30, 8'd40, 3, 1'b0);  drain();
    applyStimulus(8'd3, 8'd9, 8'd2, 8'd7, 0, 1'b1);      drain();

    // Abort a burst in its first COMPARE cycle; nothing is pushed, so no done may appear.
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    sendElement4(8'd200, 0);
    sendElement4(8'd250, 0);
    valid4 = 1'b0;
    checkOutput("midBurstNotReady", {31'd0, ready4}, 32'd0);
    resetN = 1'b0;
    @(negedge clk);
    checkResetState4("midReset4");
    resetN = 1'b1;
    @(negedge clk);
    applyStimulus(8'd1, 8'd2, 8'd3, 8'd4, 0, 1'b0);      drain();

    for (int r = 0; r < 3; r++) begin
      applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), r, 1'b0);
      drain();
    end

    applySingle(8'd42);  drain();
    applySingle(8'd0);   drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
